// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
//   arb_state_t : arbiter FSM state encoding
//   MAX_NM      : largest supported master count
//   PTR_W       : width of a priority pointer able to address MAX_NM masters
//   rr_pick()   : one-hot pick of the first requester at or after ptr, wrapping
package wb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int MAX_NM = 16;
    localparam int PTR_W  = 4;

    // Requests are zero-padded to MAX_NM, so wrapping modulo MAX_NM gives
    // the same winner as wrapping modulo the real master count.
    function automatic logic [MAX_NM-1:0] rr_pick(input logic [MAX_NM-1:0] req,
                                                  input logic [PTR_W-1:0]  ptr);
        logic [MAX_NM-1:0] gnt;
        logic [PTR_W-1:0]  idx;
        logic              found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_NM; i++) begin
            idx = ptr + PTR_W'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// Bus bundle between NM Wishbone classic masters, the arbiter and one slave.
//   m_*     : per-master request vectors and per-master responses
//   s_*     : single shared slave port
// Modports:
//   slave   : arbiter's face towards the masters (it is their slave)
//   master  : arbiter's face towards the shared slave (it is its master)
interface wb_arbiter_rr_if #(
    parameter int NM = 4,
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [NM-1:0]         m_cyc;
    logic [NM-1:0]         m_stb;
    logic [NM-1:0]         m_we;
    logic [NM-1:0][AW-1:0] m_adr;
    logic [NM-1:0][DW-1:0] m_dat_i;
    logic [DW-1:0]         m_dat_o;
    logic [NM-1:0]         m_ack;
    logic [NM-1:0]         m_err;
    logic [NM-1:0]         m_stall;

    logic                  s_cyc;
    logic                  s_stb;
    logic                  s_we;
    logic [AW-1:0]         s_adr;
    logic [DW-1:0]         s_dat_o;
    logic [DW-1:0]         s_dat_i;
    logic                  s_ack;

    modport slave (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_i,
        output m_dat_o, m_ack, m_err, m_stall
    );

    modport master (
        output s_cyc, s_stb, s_we, s_adr, s_dat_o,
        input  s_dat_i, s_ack
    );
endinterface

// File: rtl/wb_arb_mux.sv
// Combinational owner-indexed request mux and response demux.
//   i_active        : arbiter is in GRANT
//   i_owner         : index of the granted master
//   i_timeout       : watchdog firing this cycle
//   i_m_*           : per-master request signals
//   i_s_ack         : slave ack
//   o_s_*           : request presented to the slave
//   o_m_ack/err     : one-hot (or zero) responses to the owner
//   o_m_stall       : 1 for every master that is not the owner
//   o_owner_cyc/stb : raw owner cyc/stb for the FSM and watchdog
module wb_arb_mux #(
    parameter int NM = 4,
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int IW = 2
) (
    input  logic                  i_active,
    input  logic [IW-1:0]         i_owner,
    input  logic                  i_timeout,
    input  logic [NM-1:0]         i_m_cyc,
    input  logic [NM-1:0]         i_m_stb,
    input  logic [NM-1:0]         i_m_we,
    input  logic [NM-1:0][AW-1:0] i_m_adr,
    input  logic [NM-1:0][DW-1:0] i_m_dat,
    input  logic                  i_s_ack,
    output logic                  o_s_cyc,
    output logic                  o_s_stb,
    output logic                  o_s_we,
    output logic [AW-1:0]         o_s_adr,
    output logic [DW-1:0]         o_s_dat,
    output logic [NM-1:0]         o_m_ack,
    output logic [NM-1:0]         o_m_err,
    output logic [NM-1:0]         o_m_stall,
    output logic                  o_owner_cyc,
    output logic                  o_owner_stb
);
    logic [NM-1:0] w_sel;

    assign w_sel       = i_active ? (NM'(1) << i_owner) : '0;

    assign o_owner_cyc = i_active & i_m_cyc[i_owner];
    assign o_owner_stb = i_active & i_m_stb[i_owner];

    assign o_s_cyc     = o_owner_cyc;
    // The watchdog cycle withdraws the strobe so a late ack cannot also land.
    assign o_s_stb     = o_owner_stb & ~i_timeout;
    assign o_s_we      = i_active & i_m_we[i_owner];
    assign o_s_adr     = i_active ? i_m_adr[i_owner] : '0;
    assign o_s_dat     = i_active ? i_m_dat[i_owner] : '0;

    // Acks without a live strobe (idle, stb low, watchdog cycle) are dropped.
    assign o_m_ack     = (o_s_stb & i_s_ack) ? w_sel : '0;
    assign o_m_err     = i_timeout ? w_sel : '0;
    assign o_m_stall   = ~w_sel;
endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone classic slave among NM masters.
// Grants per bus cycle (cyc), locks the grant until the owner drops cyc and
// terminates unacknowledged strobes with a one-cycle error after TIMEOUT.
//   i_clk  : bus clock
//   i_rst  : asynchronous active-high reset
//   m_bus  : master-side signals (slave modport)
//   s_bus  : slave-side signals (master modport)
//   o_gnt  : current one-hot grant
//
// state | meaning
// IDLE  | no owner, s_cyc=0; arbitrate among m_cyc from the pointer
// GRANT | owner routed to the slave until its cyc falls
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int NM      = 4,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    wb_arbiter_rr_if.slave  m_bus,
    wb_arbiter_rr_if.master s_bus,
    output logic [NM-1:0]   o_gnt
);
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t        r_state;
    logic [NM-1:0]     r_gnt;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     r_ptr;
    logic [WW-1:0]     r_wdog;

    logic [MAX_NM-1:0] w_pick;
    logic [IW-1:0]     w_pick_idx;
    logic [IW-1:0]     w_ptr_next;
    logic              w_active;
    logic              w_owner_cyc;
    logic              w_owner_stb;
    logic              w_timeout;

    assign w_pick     = rr_pick(MAX_NM'(m_bus.m_cyc), PTR_W'(r_ptr));
    assign w_active   = (r_state == GRANT);
    assign w_ptr_next = (r_owner == IW'(NM - 1)) ? '0 : r_owner + 1'b1;
    assign w_timeout  = (TIMEOUT != 0) && w_active && w_owner_stb &&
                        (r_wdog == WW'(TIMEOUT));

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < MAX_NM; i++) begin
            if (w_pick[i]) w_pick_idx = IW'(i);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_wdog  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wdog <= '0;
                    if (|m_bus.m_cyc) begin
                        r_gnt   <= w_pick[NM-1:0];
                        r_owner <= w_pick_idx;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!w_owner_cyc) begin
                        r_gnt   <= '0;
                        r_ptr   <= w_ptr_next;
                        r_wdog  <= '0;
                        r_state <= IDLE;
                    end else if (w_timeout || !w_owner_stb || s_bus.s_ack) begin
                        r_wdog <= '0;
                    end else if (TIMEOUT != 0) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    wb_arb_mux #(
        .NM (NM),
        .AW (AW),
        .DW (DW),
        .IW (IW)
    ) u_mux (
        .i_active    (w_active),
        .i_owner     (r_owner),
        .i_timeout   (w_timeout),
        .i_m_cyc     (m_bus.m_cyc),
        .i_m_stb     (m_bus.m_stb),
        .i_m_we      (m_bus.m_we),
        .i_m_adr     (m_bus.m_adr),
        .i_m_dat     (m_bus.m_dat_i),
        .i_s_ack     (s_bus.s_ack),
        .o_s_cyc     (s_bus.s_cyc),
        .o_s_stb     (s_bus.s_stb),
        .o_s_we      (s_bus.s_we),
        .o_s_adr     (s_bus.s_adr),
        .o_s_dat     (s_bus.s_dat_o),
        .o_m_ack     (m_bus.m_ack),
        .o_m_err     (m_bus.m_err),
        .o_m_stall   (m_bus.m_stall),
        .o_owner_cyc (w_owner_cyc),
        .o_owner_stb (w_owner_stb)
    );

    assign m_bus.m_dat_o = s_bus.s_dat_i;
    assign o_gnt         = r_gnt;
endmodule
